// File: rtl/music_player_seq_pkg.sv
// Shared definitions for the music player sequencer:
// FSM state encodings and constant-width helper functions.
package music_player_seq_pkg;

    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_FETCH   = 2'd2;
    localparam logic [1:0] ST_EMIT    = 2'd3;

    function automatic int mp_clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int mp_max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/music_player_seq_button_edge.sv
// Rising-edge detector for a front-panel button level.
// History resets to 1 so a button held through reset gives no event.
module mp_button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next history value is simply the current level
    always_comb begin
        prev_d = btn;
    end

    // Level history register, set to 1 while in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/music_player_seq.sv
// Multi-song, multi-channel playback sequencer fetching frames from a sample ROM.
// Build option MUSIC_PLAYER_REPEAT_EN: loop the current song instead of auto-advancing.
module music_player_seq
    import music_player_seq_pkg::*;
#(
    parameter int NUM_SONGS       = 4,
    parameter int CHANNELS        = 2,
    parameter int SAMPLE_W        = 16,
    parameter int FRAMES_PER_SONG = 1024,
    localparam int ADDR_W = mp_clog2(NUM_SONGS * FRAMES_PER_SONG * CHANNELS),
    localparam int SONG_W = mp_max1(mp_clog2(NUM_SONGS))
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_button,
    input  logic                         next_button,
    input  logic                         new_frame,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    input  logic [SAMPLE_W-1:0]          mem_data,
    output logic [CHANNELS*SAMPLE_W-1:0] sample_out,
    output logic                         new_sample_generated,
    output logic                         play_led,
    output logic [SONG_W-1:0]            song_led,
    output logic                         overrun
);

    localparam int OFF_W   = mp_max1(mp_clog2(FRAMES_PER_SONG));
    localparam int CH_W    = mp_max1(mp_clog2(CHANNELS));
    localparam int FRAME_W = CHANNELS * SAMPLE_W;

    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(CHANNELS - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF    = OFF_W'(FRAMES_PER_SONG - 1);
    localparam logic [SONG_W-1:0] LAST_SONG   = SONG_W'(NUM_SONGS - 1);
    localparam logic [ADDR_W-1:0] SONG_STRIDE = ADDR_W'(FRAMES_PER_SONG * CHANNELS);
    localparam logic [ADDR_W-1:0] CH_STRIDE   = ADDR_W'(CHANNELS);

    logic [1:0]         state_q, state_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               pause_pend_q, pause_pend_d;
    logic               next_pend_q, next_pend_d;
    logic [FRAME_W-1:0] buf_q, buf_d;
    logic [FRAME_W-1:0] out_q, out_d;
    logic [FRAME_W-1:0] frame_asm;
    logic [SONG_W-1:0]  song_nxt;
    logic               play_evt;
    logic               next_evt;
    logic               pause_now;
    logic               next_now;

    mp_button_edge u_play_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (play_button),
        .rise  (play_evt)
    );

    mp_button_edge u_next_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (next_button),
        .rise  (next_evt)
    );

    assign song_nxt  = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
    assign pause_now = pause_pend_q ^ play_evt;
    assign next_now  = next_pend_q | next_evt;

    // Last channel is taken straight off the ROM bus in the emit cycle
    always_comb begin
        frame_asm = buf_q;
        frame_asm[(CHANNELS-1)*SAMPLE_W +: SAMPLE_W] = mem_data;
    end

    // Sequencer next-state, song/frame counters and sample capture
    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        off_d        = off_q;
        ch_d         = ch_q;
        pause_pend_d = pause_pend_q;
        next_pend_d  = next_pend_q;
        buf_d        = buf_q;
        out_d        = out_q;
        case (state_q)
            ST_PAUSED: begin
                if (play_evt) begin
                    state_d = ST_PLAYING;
                end
                if (next_evt) begin
                    song_d = song_nxt;
                    off_d  = '0;
                end
            end
            ST_PLAYING: begin
                if (play_evt) begin
                    state_d = ST_PAUSED;
                end else if (new_frame) begin
                    state_d = ST_FETCH;
                    ch_d    = '0;
                end
                if (next_evt) begin
                    song_d = song_nxt;
                    off_d  = '0;
                end
            end
            ST_FETCH: begin
                pause_pend_d = pause_now;
                next_pend_d  = next_now;
                if (ch_q != '0) begin
                    buf_d[(int'(ch_q) - 1) * SAMPLE_W +: SAMPLE_W] = mem_data;
                end
                if (ch_q == LAST_CH) begin
                    state_d = ST_EMIT;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: begin
                out_d = frame_asm;
                if (next_now) begin
                    off_d  = '0;
                    song_d = song_nxt;
                end else if (off_q == LAST_OFF) begin
                    off_d = '0;
`ifdef MUSIC_PLAYER_REPEAT_EN
                    song_d = song_q;
`else
                    song_d = song_nxt;
`endif
                end else begin
                    off_d = off_q + OFF_W'(1);
                end
                state_d      = pause_now ? ST_PAUSED : ST_PLAYING;
                pause_pend_d = 1'b0;
                next_pend_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PAUSED;
            song_q       <= '0;
            off_q        <= '0;
            ch_q         <= '0;
            pause_pend_q <= 1'b0;
            next_pend_q  <= 1'b0;
            buf_q        <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            off_q        <= off_d;
            ch_q         <= ch_d;
            pause_pend_q <= pause_pend_d;
            next_pend_q  <= next_pend_d;
            buf_q        <= buf_d;
            out_q        <= out_d;
        end
    end

    assign mem_addr = ADDR_W'(song_q) * SONG_STRIDE
                    + ADDR_W'(off_q) * CH_STRIDE
                    + ADDR_W'(ch_q);
    assign mem_rd               = (state_q == ST_FETCH);
    assign new_sample_generated = (state_q == ST_EMIT);
    assign sample_out           = new_sample_generated ? frame_asm : out_q;
    assign play_led             = (state_q != ST_PAUSED) && !pause_pend_q;
    assign song_led             = song_q;
    assign overrun              = new_frame &&
                                  ((state_q == ST_FETCH) || (state_q == ST_EMIT));

endmodule
